// File: rtl/fnd_ctrl_watch.sv
// 4-digit multiplexed 7-segment driver for the watch: HH.MM / SS.CC views, edit blink, 1 Hz dp.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the hour tens digit when the hour is below 10.
module fnd_ctrl_watch #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  input  logic [1:0] sel_pos,
  input  logic       edit,
  input  logic       disp_mode,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data
);

  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]  r_scan_cnt;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic [1:0]         r_idx;
  logic               r_blink_hide;
  logic [6:0]         r_snap_msec;
  logic [5:0]         r_snap_sec;
  logic [5:0]         r_snap_min;
  logic [4:0]         r_snap_hour;
  logic [3:0]         r_fnd_com;
  logic [7:0]         r_fnd_data;

  logic       w_scan_tick;
  logic       w_blink_tick;
  logic [6:0] w_val;
  logic [3:0] w_tens;
  logic [3:0] w_ones;
  logic       w_sel_hit;
  logic [7:0] w_seg;
  logic [3:0] w_com;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign w_scan_tick  = (r_scan_cnt == SCAN_LAST);
  assign w_blink_tick = (r_blink_cnt == BLINK_LAST);

  // Snapshot is taken only on the 3->0 wrap so a whole frame shows one coherent sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan_cnt  <= '0;
      r_idx       <= 2'd0;
      r_snap_msec <= 7'd0;
      r_snap_sec  <= 6'd0;
      r_snap_min  <= 6'd0;
      r_snap_hour <= 5'd0;
    end else if (w_scan_tick) begin
      r_scan_cnt <= '0;
      r_idx      <= r_idx + 2'd1;
      if (r_idx == 2'd3) begin
        r_snap_msec <= msec;
        r_snap_sec  <= sec;
        r_snap_min  <= min;
        r_snap_hour <= hour;
      end
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blink_cnt  <= '0;
      r_blink_hide <= 1'b0;
    end else if (!edit) begin
      r_blink_cnt  <= '0;
      r_blink_hide <= 1'b0;
    end else if (w_blink_tick) begin
      r_blink_cnt  <= '0;
      r_blink_hide <= ~r_blink_hide;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  always_comb begin
    w_val = 7'd0;
    case ({disp_mode, r_idx[1]})
      2'b01:   w_val = {2'b00, r_snap_hour};
      2'b00:   w_val = {1'b0, r_snap_min};
      2'b11:   w_val = {1'b0, r_snap_sec};
      default: w_val = r_snap_msec;
    endcase
  end

  assign w_tens = 4'(w_val / 7'd10);
  assign w_ones = 4'(w_val - 7'(w_tens) * 7'd10);

  always_comb begin
    w_sel_hit = 1'b0;
    case (sel_pos)
      2'd0:    w_sel_hit = disp_mode & r_idx[1];
      2'd1:    w_sel_hit = ~disp_mode & ~r_idx[1];
      2'd2:    w_sel_hit = ~disp_mode & r_idx[1];
      default: w_sel_hit = 1'b0;
    endcase
  end

  // Blanking is applied before the dp so the flashing colon-dot survives edit blink.
  always_comb begin
    w_seg = (w_val > 7'd99) ? 8'hBF : seg_code(r_idx[0] ? w_tens : w_ones);
`ifdef LEADING_ZERO_BLANK_EN
    if (!disp_mode && (r_idx == 2'd3) && (r_snap_hour < 5'd10))
      w_seg = 8'hFF;
`else
`endif
    if (edit && r_blink_hide && w_sel_hit)
      w_seg = 8'hFF;
    if ((r_idx == 2'd2) && (disp_mode || (r_snap_msec < 7'd50)))
      w_seg[7] = 1'b0;
  end

  assign w_com = ~(4'b0001 << r_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fnd_com  <= 4'hF;
      r_fnd_data <= 8'hFF;
    end else begin
      r_fnd_com  <= w_com;
      r_fnd_data <= w_seg;
    end
  end

  assign fnd_com  = r_fnd_com;
  assign fnd_data = r_fnd_data;

endmodule
